keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display driver.
- Drives the 4 column lines of a 4x4 matrix keypad (Pmod KYPD style) one at a time, active low, and reads the 4 row lines back.
- Debounces the decoded key and reports a single stable hex key code with a one-cycle valid pulse.
- The downstream consumer is the display/control logic, which receives key_hex in the same 4-bit hex format the display driver accepts.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_debounce.sv | 87 ++++++++
 rtl/keypad_scanner.sv | 74 +++++++
 tb/tb_keypad_scanner.sv | 104 ++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, debounce state encoding and sweep result type for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;
  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } result_t;
  localparam result_t NONE = '{hit: 1'b0, code: 4'h0};
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad lines, enable and key report between scanner and its environment
interface keypad_scanner_if;
  logic       en;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_hex;
  logic       key_valid;
  logic       key_held;
  modport master(input en, rows, output cols, key_hex, key_valid, key_held);
  modport slave(output en, rows, input cols, key_hex, key_valid, key_held);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a press or release after DEBOUNCE_SCANS identical sweep results
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sweep_done,
  input  logic       sweep_valid,
  input  logic [3:0] sweep_code,
  output logic [3:0] key_hex,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] cand;
  logic same_held, same_cand, last_cnt;
  always_comb begin
    same_held = sweep_valid && sweep_code == key_hex;
    same_cand = sweep_valid && sweep_code == cand;
    last_cnt = cnt == CW'(DEBOUNCE_SCANS - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      key_hex <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      cnt <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sweep_done) begin
        case (state)
          IDLE: if (sweep_valid) begin
            if (DEBOUNCE_SCANS == 1) begin
              state <= HELD;
              key_hex <= sweep_code;
              key_valid <= 1'b1;
              key_held <= 1'b1;
            end else begin
              state <= PRESS_PEND;
              cand <= sweep_code;
              cnt <= CW'(1);
            end
          end
          PRESS_PEND: if (!sweep_valid) begin
            state <= IDLE;
            cnt <= '0;
          end else if (!same_cand) begin
            cand <= sweep_code;
            cnt <= CW'(1);
          end else if (last_cnt) begin
            state <= HELD;
            cnt <= '0;
            key_hex <= cand;
            key_valid <= 1'b1;
            key_held <= 1'b1;
          end else cnt <= cnt + CW'(1);
          HELD: if (!same_held) begin
            state <= DEBOUNCE_SCANS == 1 ? IDLE : RELEASE_PEND;
            cnt <= DEBOUNCE_SCANS == 1 ? '0 : CW'(1);
            key_held <= DEBOUNCE_SCANS != 1;
          end
          RELEASE_PEND: if (same_held) begin
            state <= HELD;
            cnt <= '0;
          end else if (last_cnt) begin
            state <= IDLE;
            cnt <= '0;
            key_held <= 1'b0;
          end else cnt <= cnt + CW'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives keypad columns one at a time, decodes each full sweep and debounces the key
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 4000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic rst,
  keypad_scanner_if.master bus
);
  localparam int DW = $clog2(SCAN_PERIOD);
  logic [3:0] r1, r2, lows, acc_code, code;
  logic [DW-1:0] dwell;
  logic [1:0] col, acc_n, tot, row;
  logic [2:0] n;
  logic run, last, done;
  result_t res;
  assign bus.cols = run ? ~(4'b1 << col) : 4'hF;
  // acc_n saturates at 2: anything beyond one low in a sweep is ambiguous
  always_comb begin
    lows = ~r2;
    n = '0;
    row = '0;
    for (int i = 0; i < 4; i++) if (lows[i]) begin
      n = n + 3'd1;
      row = 2'(i);
    end
    tot = (n > 3'd1 || acc_n == 2'd2) ? 2'd2 : acc_n + n[1:0];
    code = acc_n != 2'd0 ? acc_code : KEY_MAP[row][col];
    last = dwell == DW'(SCAN_PERIOD - 1);
    done = run && bus.en && last && col == 2'd3;
    res = tot == 2'd1 ? result_t'{1'b1, code} : NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= 4'hF;
      r2 <= 4'hF;
      run <= 1'b0;
      dwell <= '0;
      col <= '0;
      acc_n <= '0;
      acc_code <= '0;
    end else begin
      r1 <= bus.rows;
      r2 <= r1;
      run <= bus.en;
      if (!run || !bus.en) begin
        dwell <= '0;
        col <= '0;
        acc_n <= '0;
        acc_code <= '0;
      end else begin
        dwell <= last ? '0 : dwell + DW'(1);
        if (last) begin
          col <= col + 2'd1;
          acc_n <= done ? 2'd0 : tot;
          acc_code <= code;
        end
      end
    end
  end
  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .sweep_done(done),
    .sweep_valid(res.hit),
    .sweep_code(res.code),
    .key_hex(bus.key_hex),
    .key_valid(bus.key_valid),
    .key_held(bus.key_held)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table-driven sweep steps plus enable and reset corner sequences
module tb_keypad_scanner;
  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    logic [3:0]  hex;
    logic        held;
    int          pulses;
  } step_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pressed = '0;
  int errors = 0;
  int checks = 0;
  int vcount = 0;
  step_t tbl [17];
  keypad_scanner_if bus();
  keypad_scanner #(.SCAN_PERIOD(4), .DEBOUNCE_SCANS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.rows = 4'hF;
    for (int r = 0; r < 4; r++) bus.rows[r] = ~(|(pressed[r*4 +: 4] & ~bus.cols));
  end
  always @(posedge clk) if (bus.key_valid) vcount <= vcount + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_step(input string nm, input step_t s);
    int base;
    pressed = s.keys;
    base = vcount;
    repeat (16 * s.sweeps) @(negedge clk);
    chk({nm, " key_hex"}, bus.key_hex, s.hex);
    chk({nm, " key_held"}, bus.key_held, s.held);
    chk({nm, " pulses"}, vcount - base, s.pulses);
    chk({nm, " cols"}, bus.cols, 4'hE);
  endtask
  initial begin
    logic [3:0] e;
    tbl[0]  = '{16'h0000, 1, 4'h0, 1'b0, 0};
    tbl[1]  = '{16'h0020, 2, 4'h0, 1'b0, 0};
    tbl[2]  = '{16'h0020, 1, 4'h5, 1'b1, 1};
    tbl[3]  = '{16'h0020, 3, 4'h5, 1'b1, 0};
    tbl[4]  = '{16'h0000, 2, 4'h5, 1'b1, 0};
    tbl[5]  = '{16'h0000, 1, 4'h5, 1'b0, 0};
    tbl[6]  = '{16'h0400, 1, 4'h5, 1'b0, 0};
    tbl[7]  = '{16'h0000, 1, 4'h5, 1'b0, 0};
    tbl[8]  = '{16'h0400, 2, 4'h5, 1'b0, 0};
    tbl[9]  = '{16'h0400, 1, 4'h9, 1'b1, 1};
    tbl[10] = '{16'h0000, 3, 4'h9, 1'b0, 0};
    tbl[11] = '{16'h0003, 5, 4'h9, 1'b0, 0};
    tbl[12] = '{16'h0002, 2, 4'h9, 1'b0, 0};
    tbl[13] = '{16'h0002, 1, 4'h2, 1'b1, 1};
    tbl[14] = '{16'h0000, 3, 4'h2, 1'b0, 0};
    tbl[15] = '{16'h8000, 2, 4'h2, 1'b0, 0};
    tbl[16] = '{16'h8000, 1, 4'hD, 1'b1, 1};
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cols", bus.cols, 4'hF);
    chk("reset key_hex", bus.key_hex, 4'h0);
    chk("reset key_valid", bus.key_valid, 0);
    chk("reset key_held", bus.key_held, 0);
    rst = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = ~(4'b1 << (k / 4));
      chk($sformatf("scan cols %0d", k), bus.cols, e);
    end
    repeat (2) @(negedge clk);
    chk("idle pulses", vcount, 0);
    chk("idle key_held", bus.key_held, 0);
    for (int i = 0; i < 17; i++) run_step($sformatf("step%0d", i), tbl[i]);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en low cols", bus.cols, 4'hF);
    chk("en low key_held", bus.key_held, 0);
    chk("en low key_hex", bus.key_hex, 4'hD);
    @(negedge clk);
    chk("en low cols 2", bus.cols, 4'hF);
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    run_step("reen D pend", '{16'h8000, 2, 4'hD, 1'b0, 0});
    run_step("reen D accept", '{16'h8000, 1, 4'hD, 1'b1, 1});
    run_step("D release", '{16'h0000, 3, 4'hD, 1'b0, 0});
    run_step("A pend", '{16'h0008, 2, 4'hD, 1'b0, 0});
    rst = 1'b1;
    @(negedge clk);
    chk("rst cols", bus.cols, 4'hF);
    chk("rst key_hex", bus.key_hex, 4'h0);
    chk("rst key_valid", bus.key_valid, 0);
    chk("rst key_held", bus.key_held, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_step("A repend", '{16'h0008, 2, 4'h0, 1'b0, 0});
    run_step("A accept", '{16'h0008, 1, 4'hA, 1'b1, 1});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
